// File: rtl/keypad_pkg.sv
// Shared keypad/display types: scan FSM states, column strobe patterns, row helpers.
// Latency: none, declarations and pure functions only.
// Backpressure: none.
package keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } state_t;

    // Active-low one-cold column strobes; the display scanner drives its digits in the same order.
    localparam logic [3:0] COL0 = 4'b0111;
    localparam logic [3:0] COL1 = 4'b1011;
    localparam logic [3:0] COL2 = 4'b1101;
    localparam logic [3:0] COL3 = 4'b1110;

    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        logic [3:0] s;
        s = COL0;
        unique case (idx)
            2'd0: s = COL0;
            2'd1: s = COL1;
            2'd2: s = COL2;
            2'd3: s = COL3;
        endcase
        return s;
    endfunction

    // True when exactly one active-low row line is pulled down.
    function automatic logic single_low(input logic [3:0] rows);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (!rows[i]) n++;
        end
        return (n == 1);
    endfunction

    // Bit index of the low row; only meaningful when single_low() holds.
    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs, with a settable idle value.
// Latency: 2 clk cycles from pin to q.
// Backpressure: none, free-running sampler.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; reset loads the idle pin level so no false edge appears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: strobes columns, debounces press/release, holds the key code for a consumer.
// Latency: 2-cycle sync + up to SCAN_DIV dwell + DEBOUNCE_CNT stable cycles from press to key_valid.
// Backpressure: key_valid holds until key_ack; a newer key overwrites it and pulses overrun.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 250000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ack,
    output logic             key_pressed,
    output logic             overrun
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_MAX    = BW'(DEBOUNCE_CNT - 1);

    state_t      state;
    logic [DW-1:0] dwell;
    logic [BW-1:0] db_cnt;
    logic [1:0]  col_idx;
    logic [1:0]  row_idx;
    logic [3:0]  cap_rows;
    logic [3:0]  rs;
    logic [1:0]  col_next;

    assign col_next = col_idx + 2'd1;

    // Rows idle high, so the synchronizer resets to all-released.
    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (4'hF)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_in),
        .q     (rs)
    );

    // Scan/debounce FSM plus the valid/ack hold register; a key load overrides a same-cycle ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SCAN;
            dwell       <= '0;
            db_cnt      <= '0;
            col_idx     <= 2'd0;
            row_idx     <= 2'd0;
            cap_rows    <= 4'hF;
            col_out     <= COL0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (key_ack && key_valid) key_valid <= 1'b0;

            unique case (state)
                SCAN: begin
                    if (dwell == DWELL_MAX) begin
                        dwell <= '0;
                        if (single_low(rs)) begin
                            // Column stays frozen while this row is qualified.
                            state    <= DB_PRESS;
                            cap_rows <= rs;
                            row_idx  <= low_index(rs);
                            db_cnt   <= '0;
                        end else begin
                            // Idle or ghosted (several rows low): keep scanning.
                            col_idx <= col_next;
                            col_out <= col_strobe(col_next);
                        end
                    end else begin
                        dwell <= dwell + DW'(1);
                    end
                end

                DB_PRESS: begin
                    if (rs == cap_rows) begin
                        if (db_cnt == DB_MAX) begin
                            state       <= HELD;
                            key_code    <= {row_idx, col_idx};
                            key_valid   <= 1'b1;
                            key_pressed <= 1'b1;
                            overrun     <= key_valid && !key_ack;
                        end else begin
                            db_cnt <= db_cnt + BW'(1);
                        end
                    end else begin
                        // Bounce: resume scanning on the same column.
                        state <= SCAN;
                        dwell <= '0;
                    end
                end

                HELD: begin
                    // Other keys are ignored; only a full release is tracked.
                    if (rs == 4'hF) begin
                        state  <= DB_REL;
                        db_cnt <= '0;
                    end
                end

                DB_REL: begin
                    if (rs != 4'hF) begin
                        state <= HELD;
                    end else if (db_cnt == DB_MAX) begin
                        state       <= SCAN;
                        key_pressed <= 1'b0;
                        dwell       <= '0;
                        col_idx     <= col_next;
                        col_out     <= col_strobe(col_next);
                    end else begin
                        db_cnt <= db_cnt + BW'(1);
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end

endmodule
